deserializer_fsm: RTL and testbench
===================================

DESERIALIZER_FSM -- requirements
Module: deserializer_fsm

Interface
REQ-001 Parameter: LENGTH, default 24, parallel word width in bits (range 2..64).
REQ-002 Derived constant: CNT_BITS = $clog2(LENGTH+1), bit-counter width.
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_en  in  1  clock enable; when low, all registers hold their values.
REQ-006 i_din  in  1  serial data bit, LSB of word first.
REQ-007 i_din_valid  in  1  upstream asserts: i_din holds a valid bit.
REQ-008 o_ready  out  1  block can accept a serial bit this cycle.
REQ-009 ov_dout  out  LENGTH  assembled parallel word.
REQ-010 o_dout_valid  out  1  ov_dout holds a complete word.
REQ-011 i_ready  in  1  downstream accepts ov_dout this cycle.

Function
REQ-012 The FSM SHALL have three states: S_IDLE, S_SHIFT, S_OUT.
REQ-013 S_IDLE SHALL clear the shift register and counter, then move to S_SHIFT on the next enabled cycle.
REQ-014 o_ready SHALL be a Moore output, high iff state == S_SHIFT and i_en high; no combinational path from i_din_valid or i_ready.
REQ-015 Bit transfer occurs on an edge where i_en && o_ready && i_din_valid; i_din SHALL be shifted in at bit LENGTH-1 and the register shifted right by one.
REQ-016 After exactly LENGTH transfers, the first bit received SHALL be at ov_dout[0] and the last at ov_dout[LENGTH-1].
REQ-017 The counter SHALL increment per transfer; on the transfer making count == LENGTH, the FSM SHALL go to S_OUT and the counter SHALL clear to 0.
REQ-018 Gaps in i_din_valid while in S_SHIFT SHALL stall the counter; no bit lost or duplicated.
REQ-019 Latency: o_dout_valid SHALL rise on the edge that accepts the last bit (visible the cycle after that transfer).
REQ-020 In S_OUT, o_dout_valid SHALL be high and ov_dout SHALL be stable until a cycle with i_en && i_ready.
REQ-021 On i_en && i_ready in S_OUT, the FSM SHALL return to S_SHIFT and o_dout_valid SHALL drop the next cycle; o_ready rises that same next cycle.
REQ-022 No serial bit SHALL be accepted in S_OUT; i_din_valid there is ignored (upstream holds it).
REQ-023 ov_dout SHALL update only on entry to S_OUT; it holds the last word otherwise.
REQ-024 Illegal state encodings SHALL recover to S_IDLE on the next enabled cycle.
REQ-025 i_en low mid-word SHALL freeze counter, shift register, state and outputs; resuming SHALL continue the word without loss.

Reset
REQ-026 On i_rst: state = S_IDLE, counter = 0, shift register = 0, ov_dout = 0, o_dout_valid = 0; o_ready therefore 0.
REQ-027 i_rst SHALL take priority over i_en and discard any partial word or pending output.
REQ-028 After i_rst releases, o_ready SHALL first assert two enabled cycles later (S_IDLE then S_SHIFT).

Structure
REQ-029 State encodings (2-bit localparams S_IDLE/S_SHIFT/S_OUT) SHALL live in a shared serial-link package used by serializer and deserializer.
REQ-030 Single module; no sub-modules; state register, next-state logic and datapath in separate processes.

Verification
REQ-031 LENGTH=24, rst then 24 bits of 0xA5C3F0 LSB-first, valid continuous, i_ready=1 -> ov_dout=0xA5C3F0, o_dout_valid high exactly 1 cycle, 1 cycle after the 24th transfer.
REQ-032 Same word, i_din_valid toggling 1,0,1,0 -> identical ov_dout=0xA5C3F0; 24 transfers counted.
REQ-033 Word 0x123456 with i_ready low 10 cycles -> o_dout_valid and ov_dout=0x123456 held 10 cycles, o_ready low throughout.
REQ-034 i_rst after 10 bits of 0xFFFFFF, then word 0x000001 -> only ov_dout=0x000001 produced; no partial word emitted.
REQ-035 i_en low 5 cycles after 12 bits of 0x0F0F0F -> no state change during gap; final ov_dout=0x0F0F0F.
REQ-036 Back-to-back words 0xAAAAAA, 0x555555 with i_ready=1 -> two valid pulses, correct words in order, no bit dropped.

Source files
------------

// File: rtl/serial_link_pkg.sv
// ============================================================================
// Module      : serial_link_pkg
// Description : Shared state encodings for the serializer/deserializer pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_link_pkg;

    typedef logic [1:0] link_state_t;

    // 2'b11 is unused; both link FSMs treat it as illegal and recover to idle
    localparam link_state_t S_IDLE  = 2'b00;
    localparam link_state_t S_SHIFT = 2'b01;
    localparam link_state_t S_OUT   = 2'b10;

endpackage : serial_link_pkg

`default_nettype wire

// File: rtl/deserializer_fsm.sv
// ============================================================================
// Module      : deserializer_fsm
// Description : LSB-first serial-to-parallel converter with valid/ready
//               handshakes on both sides and a clock enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deserializer_fsm
    import serial_link_pkg::*;
#(
    parameter int LENGTH = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_ready
);

    localparam int CNT_BITS = $clog2(LENGTH + 1);

    link_state_t         r_state;
    link_state_t         w_state_nxt;
    logic [CNT_BITS-1:0] r_cnt;
    logic [LENGTH-1:0]   r_shift;
    logic [LENGTH-1:0]   r_dout;
    logic [LENGTH-1:0]   w_shifted;
    logic                w_last;

    assign w_shifted = {i_din, r_shift[LENGTH-1:1]};
    assign w_last    = (r_cnt == CNT_BITS'(LENGTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else if (i_en) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (i_din_valid && w_last) w_state_nxt = S_OUT;
            S_OUT:   if (i_ready) w_state_nxt = S_SHIFT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The output word is captured from the shift path on the final transfer,
    // so it is valid in the same cycle the FSM first shows S_OUT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_dout  <= '0;
        end else if (i_en) begin
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_shift <= '0;
                end
                S_SHIFT: begin
                    if (i_din_valid) begin
                        r_shift <= w_shifted;
                        if (w_last) begin
                            r_cnt  <= '0;
                            r_dout <= w_shifted;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready      = i_en && (r_state == S_SHIFT);
    assign o_dout_valid = (r_state == S_OUT);
    assign ov_dout      = r_dout;

endmodule : deserializer_fsm

`default_nettype wire

// File: tb/tb_deserializer_fsm.sv
// ============================================================================
// Module      : tb_deserializer_fsm
// Description : Directed vector table plus randomized run against a
//               bit-index reference model for deserializer_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deserializer_fsm;

    localparam int LENGTH = 24;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_en;
    logic              i_din;
    logic              i_din_valid;
    logic              o_ready;
    logic [LENGTH-1:0] ov_dout;
    logic              o_dout_valid;
    logic              i_ready;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic prev_valid = 1'b0;

    deserializer_fsm #(.LENGTH(LENGTH)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_din        (i_din),
        .i_din_valid  (i_din_valid),
        .o_ready      (o_ready),
        .ov_dout      (ov_dout),
        .o_dout_valid (o_dout_valid),
        .i_ready      (i_ready)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_dout_valid === 1'b1 && prev_valid !== 1'b1) pulses++;
        prev_valid = o_dout_valid;
    end

    typedef struct {
        string       name;
        logic [23:0] word;
        bit          gap;
        int          hold;
        int          en_at;
        int          en_len;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic do_reset();
        i_rst       = 1'b1;
        i_en        = 1'b0;
        i_din       = 1'b0;
        i_din_valid = 1'b0;
        i_ready     = 1'b0;
        step();
        step();
        check("rst_ready", o_ready, 0);
        check("rst_valid", o_dout_valid, 0);
        check("rst_dout", ov_dout, 0);
        i_rst = 1'b0;
        i_en  = 1'b1;
        #1;
        check("idle_ready", o_ready, 0);
        step();
        check("first_ready", o_ready, 1);
    endtask

    // Feeds n bits of w; counts any output-valid or ready anomalies seen while shifting
    task automatic send_bits(input logic [23:0] w, input int n, input bit gap,
                             input int en_at, input int en_len, output int anomalies);
        int t;
        anomalies = 0;
        for (int b = 0; b < n; b++) begin
            if (gap && b > 0) begin
                i_din_valid = 1'b0;
                i_din       = ~w[b];
                step();
            end
            i_din       = w[b];
            i_din_valid = 1'b1;
            if (b == en_at && en_len > 0) begin
                i_en = 1'b0;
                for (int k = 0; k < en_len; k++) begin
                    step();
                    if (o_ready !== 1'b0 || o_dout_valid !== 1'b0) anomalies++;
                end
                i_en = 1'b1;
                #1;
            end
            t = 0;
            while (o_ready !== 1'b1) begin
                if (o_dout_valid === 1'b1) anomalies++;
                step();
                t++;
                if (t > 40) begin
                    checks++;
                    errors++;
                    $display("FAIL ready_timeout actual=0 required=1 bit=%0d", b);
                    finish_run();
                end
            end
            if (o_dout_valid === 1'b1) anomalies++;
            step();
        end
        i_din_valid = 1'b0;
    endtask

    task automatic send_word(input vec_t v);
        int anomalies;
        int p0;
        p0      = pulses;
        i_ready = (v.hold == 0);
        send_bits(v.word, LENGTH, v.gap, v.en_at, v.en_len, anomalies);
        check({v.name, "_shift_clean"}, anomalies, 0);
        check({v.name, "_valid"}, o_dout_valid, 1);
        check({v.name, "_dout"}, ov_dout, v.word);
        check({v.name, "_ready_low"}, o_ready, 0);
        for (int k = 0; k < v.hold - 1; k++) begin
            step();
            check({v.name, "_hold_valid"}, o_dout_valid, 1);
            check({v.name, "_hold_dout"}, ov_dout, v.word);
            check({v.name, "_hold_ready"}, o_ready, 0);
        end
        i_ready = 1'b1;
        step();
        check({v.name, "_valid_drop"}, o_dout_valid, 0);
        check({v.name, "_ready_back"}, o_ready, 1);
        check({v.name, "_pulses"}, pulses - p0, 1);
    endtask

    // Reference model: collects bit indices into a word, independent of RTL encoding
    bit          m_idle;
    bit          m_hold;
    int          m_n;
    logic [23:0] m_acc;
    logic [23:0] m_out;

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            i_rst       = (c == 0) || ($urandom_range(0, 199) == 0);
            i_en        = ($urandom_range(0, 3) != 0);
            i_din       = 1'($urandom);
            i_din_valid = ($urandom_range(0, 2) != 0);
            i_ready     = 1'($urandom);
            #1;
            if (c > 0) begin
                check("rand_ready", o_ready, i_en && !m_idle && !m_hold);
                check("rand_valid", o_dout_valid, !m_idle && m_hold);
                check("rand_dout", ov_dout, m_out);
            end
            if (i_rst) begin
                m_idle = 1; m_hold = 0; m_n = 0; m_acc = '0; m_out = '0;
            end else if (i_en) begin
                if (m_idle) begin
                    m_idle = 0; m_n = 0; m_acc = '0;
                end else if (m_hold) begin
                    if (i_ready) m_hold = 0;
                end else if (i_din_valid) begin
                    m_acc[m_n] = i_din;
                    m_n++;
                    if (m_n == LENGTH) begin
                        m_out = m_acc; m_hold = 1; m_n = 0; m_acc = '0;
                    end
                end
            end
            step();
        end
    endtask

    initial begin
        int anomalies;
        int p0;

        tbl[0] = '{"continuous", 24'hA5C3F0, 1'b0, 0,  -1, 0};
        tbl[1] = '{"gapped",     24'hA5C3F0, 1'b1, 0,  -1, 0};
        tbl[2] = '{"held",       24'h123456, 1'b0, 10, -1, 0};
        tbl[3] = '{"en_pause",   24'h0F0F0F, 1'b0, 0,  12, 5};
        tbl[4] = '{"b2b_first",  24'hAAAAAA, 1'b0, 0,  -1, 0};
        tbl[5] = '{"b2b_second", 24'h555555, 1'b0, 0,  -1, 0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_word(tbl[i]);
        end

        // Reset mid-word: the partial ones must never reach the output
        p0 = pulses;
        i_ready = 1'b1;
        send_bits(24'hFFFFFF, 10, 1'b0, -1, 0, anomalies);
        check("partial_clean", anomalies, 0);
        do_reset();
        check("partial_dropped", pulses - p0, 0);
        send_word('{"after_rst", 24'h000001, 1'b0, 0, -1, 0});

        run_random(3000);
        finish_run();
    end

endmodule : tb_deserializer_fsm

`default_nettype wire
